// File: rtl/q_sys_onchip_ram_burst_adapter.sv
// q_sys_onchip_ram_burst_adapter
//   Avalon-MM burst front-end for a single-port on-chip RAM with a
//   one-cycle read and unregistered q. Bursts arriving from the
//   interconnect are split into single-word RAM accesses, one per clock.
//   The adapter also generates the waitrequest and readdatavalid signals
//   that the RAM itself does not provide.
//
// Ports
//   clk, reset        single clock, synchronous active-high reset
//   s_address         word address of the first beat
//   s_burstcount      beats in the burst (0 -> 1, >8 -> 8)
//   s_read, s_write   commands; write has priority when both are set
//   s_writedata       write beat data
//   s_byteenable      write beat byte lanes
//   s_waitrequest     stall; a command or beat is accepted only when low
//   s_readdata        pass-through of the RAM q
//   s_readdatavalid   one pulse per returned read word
//   m_address         RAM address (registered)
//   m_byteenable      RAM byteenable (registered)
//   m_chipselect      RAM chipselect (registered)
//   m_write           RAM write (registered)
//   m_writedata       RAM writedata (registered)
//   m_readdata        RAM q
module q_sys_onchip_ram_burst_adapter #(
  parameter int ADDR_W  = 9,
  parameter int DATA_W  = 32,
  parameter int BURST_W = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [ADDR_W-1:0]   s_address,
  input  logic [BURST_W-1:0]  s_burstcount,
  input  logic                s_read,
  input  logic                s_write,
  input  logic [DATA_W-1:0]   s_writedata,
  input  logic [DATA_W/8-1:0] s_byteenable,
  output logic                s_waitrequest,
  output logic [DATA_W-1:0]   s_readdata,
  output logic                s_readdatavalid,
  output logic [ADDR_W-1:0]   m_address,
  output logic [DATA_W/8-1:0] m_byteenable,
  output logic                m_chipselect,
  output logic                m_write,
  output logic [DATA_W-1:0]   m_writedata,
  input  logic [DATA_W-1:0]   m_readdata
);

  localparam int BE_W      = DATA_W / 8;
  localparam int MAX_BURST = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RBURST = 2'd1,
    WBURST = 2'd2
  } state_t;

  state_t              state_q,        state_d;
  logic [3:0]          beats_left_q,   beats_left_d;
  logic [ADDR_W-1:0]   m_address_q,    m_address_d;
  logic [BE_W-1:0]     m_byteenable_q, m_byteenable_d;
  logic                m_chipselect_q, m_chipselect_d;
  logic                m_write_q,      m_write_d;
  logic [DATA_W-1:0]   m_writedata_q,  m_writedata_d;
  logic                rdv_q,          rdv_d;
  logic [3:0]          burst_len;

  // Legal burst lengths are 1..8; zero is treated as a single beat and
  // anything larger is clamped to the maximum.
  function automatic logic [3:0] clamp_burst(input logic [BURST_W-1:0] bc);
    if (bc == '0)
      return 4'd1;
    else if (int'(bc) > MAX_BURST)
      return 4'(MAX_BURST);
    else
      return 4'(bc);
  endfunction

  always_comb begin
    state_d        = state_q;
    beats_left_d   = beats_left_q;
    m_address_d    = m_address_q;
    m_byteenable_d = m_byteenable_q;
    m_writedata_d  = m_writedata_q;
    m_chipselect_d = 1'b0;
    m_write_d      = 1'b0;
    burst_len      = clamp_burst(s_burstcount);
    // A read issued to the RAM last cycle is sampled at this edge, so its
    // data is on q (and valid is flagged) in the following cycle.
    rdv_d          = m_chipselect_q & ~m_write_q;

    case (state_q)
      IDLE: begin
        if (s_write) begin
          // Write wins over a simultaneous read; the read is dropped.
          m_address_d    = s_address;
          m_byteenable_d = s_byteenable;
          m_writedata_d  = s_writedata;
          m_chipselect_d = 1'b1;
          m_write_d      = 1'b1;
          if (burst_len > 4'd1) begin
            state_d      = WBURST;
            beats_left_d = burst_len - 4'd1;
          end
        end else if (s_read) begin
          m_address_d    = s_address;
          m_byteenable_d = '1;
          m_chipselect_d = 1'b1;
          if (burst_len > 4'd1) begin
            state_d      = RBURST;
            beats_left_d = burst_len - 4'd1;
          end
        end
      end

      RBURST: begin
        // Address wraps naturally at the top of the RAM.
        m_address_d    = m_address_q + 1'b1;
        m_byteenable_d = '1;
        m_chipselect_d = 1'b1;
        beats_left_d   = beats_left_q - 4'd1;
        if (beats_left_q == 4'd1)
          state_d = IDLE;
      end

      WBURST: begin
        // Cycles without s_write are bubbles: nothing is issued and the
        // address holds so the next beat lands on the following word.
        if (s_write) begin
          m_address_d    = m_address_q + 1'b1;
          m_byteenable_d = s_byteenable;
          m_writedata_d  = s_writedata;
          m_chipselect_d = 1'b1;
          m_write_d      = 1'b1;
          beats_left_d   = beats_left_q - 4'd1;
          if (beats_left_q == 4'd1)
            state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      beats_left_q   <= '0;
      m_address_q    <= '0;
      m_byteenable_q <= '0;
      m_chipselect_q <= 1'b0;
      m_write_q      <= 1'b0;
      m_writedata_q  <= '0;
      rdv_q          <= 1'b0;
    end else begin
      state_q        <= state_d;
      beats_left_q   <= beats_left_d;
      m_address_q    <= m_address_d;
      m_byteenable_q <= m_byteenable_d;
      m_chipselect_q <= m_chipselect_d;
      m_write_q      <= m_write_d;
      m_writedata_q  <= m_writedata_d;
      rdv_q          <= rdv_d;
    end
  end

  // Only a read burst stalls the agent; reset holds it off as well.
  assign s_waitrequest   = reset | (state_q == RBURST);
  assign s_readdata      = m_readdata;
  assign s_readdatavalid = rdv_q;

  assign m_address    = m_address_q;
  assign m_byteenable = m_byteenable_q;
  assign m_chipselect = m_chipselect_q;
  assign m_write      = m_write_q;
  assign m_writedata  = m_writedata_q;

endmodule

// File: tb/tb_q_sys_onchip_ram_burst_adapter.sv
// Directed testbench for q_sys_onchip_ram_burst_adapter with a behavioural
// 512x32 single-port RAM (one-cycle read, byte-lane writes).
module tb_q_sys_onchip_ram_burst_adapter;

  logic        clk;
  logic        reset;
  logic [8:0]  s_address;
  logic [3:0]  s_burstcount;
  logic        s_read;
  logic        s_write;
  logic [31:0] s_writedata;
  logic [3:0]  s_byteenable;
  logic        s_waitrequest;
  logic [31:0] s_readdata;
  logic        s_readdatavalid;
  logic [8:0]  m_address;
  logic [3:0]  m_byteenable;
  logic        m_chipselect;
  logic        m_write;
  logic [31:0] m_writedata;
  logic [31:0] m_readdata;

  q_sys_onchip_ram_burst_adapter dut (
    .clk             (clk),
    .reset           (reset),
    .s_address       (s_address),
    .s_burstcount    (s_burstcount),
    .s_read          (s_read),
    .s_write         (s_write),
    .s_writedata     (s_writedata),
    .s_byteenable    (s_byteenable),
    .s_waitrequest   (s_waitrequest),
    .s_readdata      (s_readdata),
    .s_readdatavalid (s_readdatavalid),
    .m_address       (m_address),
    .m_byteenable    (m_byteenable),
    .m_chipselect    (m_chipselect),
    .m_write         (m_write),
    .m_writedata     (m_writedata),
    .m_readdata      (m_readdata)
  );

  // RAM model
  logic [31:0] mem [512];
  logic [31:0] ram_q;
  assign m_readdata = ram_q;

  always @(posedge clk) begin
    if (m_chipselect) begin
      if (m_write) begin
        for (int b = 0; b < 4; b++)
          if (m_byteenable[b]) mem[m_address][8*b +: 8] <= m_writedata[8*b +: 8];
      end else begin
        ram_q <= mem[m_address];
      end
    end
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Read-return monitor
  logic [31:0] rd_data [$];
  int          rd_cyc  [$];
  always @(negedge clk) begin
    if (s_readdatavalid) begin
      rd_data.push_back(s_readdata);
      rd_cyc.push_back(cyc);
    end
  end

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Present one command/beat, wait (bounded) until it can be accepted,
  // hold it across one edge, then release. Returns just after that edge.
  task automatic accept(input int rd, input int wr, input int a, input int bc,
                        input int d, input int be);
    int guard;
    guard        = 0;
    s_read       = rd[0];
    s_write      = wr[0];
    s_address    = 9'(a);
    s_burstcount = 4'(bc);
    s_writedata  = 32'(d);
    s_byteenable = 4'(be);
    while (s_waitrequest && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    check("accept_wait", 32'(s_waitrequest), 32'd0);
    @(posedge clk); #1;
    s_read  = 1'b0;
    s_write = 1'b0;
  endtask

  int exp_addr [4] = '{510, 511, 0, 1};
  int exp_wait [4] = '{1, 1, 1, 0};

  initial begin
    reset        = 1'b1;
    s_address    = '0;
    s_burstcount = '0;
    s_read       = 1'b0;
    s_write      = 1'b0;
    s_writedata  = '0;
    s_byteenable = '0;
    ram_q        = '0;
    for (int i = 0; i < 512; i++) mem[i] = 32'h0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_wait",  32'(s_waitrequest),   32'd1);
    check("rst_cs",    32'(m_chipselect),    32'd0);
    check("rst_wr",    32'(m_write),         32'd0);
    check("rst_rdv",   32'(s_readdatavalid), 32'd0);
    check("rst_addr",  32'(m_address),       32'd0);
    check("rst_be",    32'(m_byteenable),    32'd0);
    check("rst_wdata", m_writedata,          32'd0);
    reset = 1'b0;
    #1;
    check("post_rst_wait", 32'(s_waitrequest), 32'd0);
    @(posedge clk); #1;

    // 1: single read
    mem[5] = 32'hDEADBEEF;
    rd_data.delete(); rd_cyc.delete();
    accept(1, 0, 5, 1, 0, 0);
    check("t1_cs",   32'(m_chipselect),    32'd1);
    check("t1_addr", 32'(m_address),       32'd5);
    check("t1_wr",   32'(m_write),         32'd0);
    check("t1_rdv0", 32'(s_readdatavalid), 32'd0);
    @(posedge clk); #1;
    check("t1_rdv1", 32'(s_readdatavalid), 32'd1);
    check("t1_data", s_readdata,           32'hDEADBEEF);
    @(posedge clk); #1;
    check("t1_rdv2", 32'(s_readdatavalid), 32'd0);
    check("t1_cs_off", 32'(m_chipselect),  32'd0);

    // 2: read burst of 4 wrapping past the top of the RAM
    mem[510] = 32'hA0000510; mem[511] = 32'hA0000511;
    mem[0]   = 32'hA0000000; mem[1]   = 32'hA0000001;
    rd_data.delete(); rd_cyc.delete();
    accept(1, 0, 510, 4, 0, 0);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t2_addr%0d", i), 32'(m_address), 32'(exp_addr[i]));
      check($sformatf("t2_wait%0d", i), 32'(s_waitrequest), 32'(exp_wait[i]));
      @(posedge clk); #1;
    end
    repeat (3) @(posedge clk);
    #1;
    check("t2_count", 32'(rd_data.size()), 32'd4);
    if (rd_data.size() == 4) begin
      check("t2_d0", rd_data[0], 32'hA0000510);
      check("t2_d1", rd_data[1], 32'hA0000511);
      check("t2_d2", rd_data[2], 32'hA0000000);
      check("t2_d3", rd_data[3], 32'hA0000001);
      check("t2_contig", 32'(rd_cyc[3] - rd_cyc[0]), 32'd3);
    end

    // 3: write burst of 3 with a bubble and a partial last beat
    mem[8] = 32'hAAAAAAAA; mem[9] = 32'hAAAAAAAA; mem[10] = 32'hAAAAAAAA;
    accept(0, 1, 8, 3, 32'h11111111, 4'hF);
    check("t3_addr0", 32'(m_address), 32'd8);
    check("t3_wr0",   32'(m_write),   32'd1);
    accept(0, 1, 0, 0, 32'h22222222, 4'hF);
    check("t3_addr1", 32'(m_address), 32'd9);
    @(posedge clk); #1;
    check("t3_gap_cs",   32'(m_chipselect),  32'd0);
    check("t3_gap_wait", 32'(s_waitrequest), 32'd0);
    accept(0, 1, 0, 0, 32'h33334444, 4'h3);
    check("t3_addr2", 32'(m_address),    32'd10);
    check("t3_be2",   32'(m_byteenable), 32'd3);
    @(posedge clk); #1;
    check("t3_m8",  mem[8],  32'h11111111);
    check("t3_m9",  mem[9],  32'h22222222);
    check("t3_m10", mem[10], 32'hAAAA4444);

    // 4: read and write together in IDLE -> write only
    mem[20] = 32'h0;
    rd_data.delete(); rd_cyc.delete();
    accept(1, 1, 20, 1, 32'h12345678, 4'hF);
    check("t4_wr", 32'(m_write), 32'd1);
    repeat (4) @(posedge clk);
    #1;
    check("t4_mem", mem[20], 32'h12345678);
    check("t4_no_rdv", 32'(rd_data.size()), 32'd0);

    // 5: reset during the third cycle of an 8-beat read
    accept(1, 0, 100, 8, 0, 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    check("t5_cs",   32'(m_chipselect),    32'd0);
    check("t5_rdv",  32'(s_readdatavalid), 32'd0);
    check("t5_wait_rst", 32'(s_waitrequest), 32'd1);
    reset = 1'b0;
    rd_data.delete(); rd_cyc.delete();
    #1;
    check("t5_wait_after", 32'(s_waitrequest), 32'd0);
    repeat (4) @(posedge clk);
    #1;
    check("t5_no_rdv", 32'(rd_data.size()), 32'd0);
    check("t5_cs_off", 32'(m_chipselect),   32'd0);

    // 6: burstcount 0 then 15, back to back
    for (int i = 40; i < 56; i++) mem[i] = 32'hC0000000 | 32'(i);
    rd_data.delete(); rd_cyc.delete();
    accept(1, 0, 40, 0, 0, 0);
    accept(1, 0, 48, 15, 0, 0);
    repeat (12) @(posedge clk);
    #1;
    check("t6_count", 32'(rd_data.size()), 32'd9);
    if (rd_data.size() == 9) begin
      check("t6_d0", rd_data[0], 32'hC0000028);
      check("t6_d1", rd_data[1], 32'hC0000030);
      check("t6_d8", rd_data[8], 32'hC0000037);
      check("t6_contig", 32'(rd_cyc[8] - rd_cyc[0]), 32'd8);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
